display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed 7-segment digits (legal range 1..8).
REQ-002 Parameter DIV, default 50000, clock cycles per digit slot (legal range ≥2).
REQ-003 Parameter BLINK_SLOTS, default 64, completed frames per blink half-period (legal range ≥1).
REQ-004 Parameter SEG_ACTIVE_LOW, default 1; 1 = segment lit when driven 0 (common anode).
REQ-005 Parameter SEL_ACTIVE_LOW, default 1; 1 = digit selected when its select line is 0.
REQ-006 clock  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  1 = scanning runs; 0 = all digits deselected and counters held.
REQ-009 load  input  1  1-cycle strobe; captures value, dp, blank_mask and blink_mask into the staging register.
REQ-010 value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3..4i) belongs to digit i, digit 0 rightmost.
REQ-011 dp  input  DIGITS  decimal-point request per digit.
REQ-012 blank_mask  input  DIGITS  1 = digit i fully dark.
REQ-013 blink_mask  input  DIGITS  1 = digit i dark during the blink-off phase.
REQ-014 seg  output  7  segments a..g as seg[6]..seg[0], polarity per SEG_ACTIVE_LOW.
REQ-015 seg_dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW.
REQ-016 digit_sel  output  DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW.
REQ-017 frame_done  output  1  1-cycle pulse when the last digit slot of a frame ends.

Function
REQ-018 The prescaler SHALL count 0..DIV-1 while enable=1; at terminal count it SHALL wrap to 0 and advance the digit index.
REQ-019 The digit index SHALL step 0,1,..,DIGITS-1 and wrap to 0; frame_done SHALL pulse in the cycle the index wraps.
REQ-020 load SHALL write the staging register in the cycle it is sampled high; a later load before the frame boundary SHALL overwrite the earlier one.
REQ-021 The display register SHALL take the staging contents only at the frame boundary (index wrap), so no frame mixes old and new data.
REQ-022 A load and a frame boundary in the same cycle SHALL let the boundary take the pre-load staging contents; the new data SHALL appear at the following frame.
REQ-023 Font (segments a..g lit, 1 = lit): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-024 seg, seg_dp and digit_sel SHALL be registered: they reflect the current index one cycle after the index changes.
REQ-025 A blink phase flag SHALL toggle after every BLINK_SLOTS frame_done pulses; phase 0 = visible.
REQ-026 Digit i SHALL be dark (all segments and dp unlit, digit_sel still asserted) when blank_mask[i]=1, or when blink_mask[i]=1 and phase=1.
REQ-027 enable=0 SHALL deassert all digit_sel lines and unlight all segments on the next edge, holding prescaler, index, phase and frame count; staging loads SHALL still be accepted.
REQ-028 Re-asserting enable SHALL resume scanning from the held index and prescaler values.

Reset
REQ-029 reset=1 SHALL immediately clear prescaler, index, frame count, phase, staging and display registers, deassert digit_sel, unlight seg/seg_dp and drive frame_done=0, including mid-slot and mid-load.
REQ-030 After reset release, the first frame SHALL show digit 0 with value 0, all digits visible.

Verification
REQ-031 DIGITS=4, DIV=4: enable=1, load value=16'h12AF. After the boundary, slots show F,A,2,1 on digits 0..3; each digit_sel line is asserted 4 cycles per 16-cycle frame.
REQ-032 Display 16'h1234 active, load 16'h5678 mid-frame. The current frame stays 1234; the next frame shows 5678. Repeat with load coincident with frame_done: 5678 appears one frame later.
REQ-033 BLINK_SLOTS=2, blink_mask=4'b0010. Digit 1 is dark for frames 3-4, lit for frames 5-6, and so on; the other digits are never dark.
REQ-034 blank_mask=4'b1000, dp=4'b0001. Digit 3 is always unlit; seg_dp is lit only during digit 0 slots; check both polarities via the SEG_ACTIVE_LOW and SEL_ACTIVE_LOW parameters.
REQ-035 Drop enable for 10 cycles mid-slot of digit 2. Outputs go inactive and frame_done stays 0. On re-enable, digit 2 finishes its remaining slot cycles.
REQ-036 Assert reset asynchronously between clock edges mid-frame. All outputs go inactive without a clock edge; after release, digit 0 shows 0.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed driver for DIGITS common-select 7-segment
// digits. A prescaler divides the clock into digit slots of DIV cycles; the
// digit index walks 0..DIGITS-1 and each full walk is one frame. New data is
// captured into a staging register on load and transferred to the display
// register only at the frame boundary, so a frame never mixes old and new
// contents. A blink phase toggles every BLINK_SLOTS frames.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high
//   enable      1 = scan; 0 = outputs dark and counters held
//   load        1-cycle strobe capturing value/dp/blank_mask/blink_mask
//   value       4*DIGITS hex nibbles, nibble i for digit i (digit 0 rightmost)
//   dp          per-digit decimal point request
//   blank_mask  per-digit force dark
//   blink_mask  per-digit dark during blink-off phase
//   seg         segments a..g on seg[6]..seg[0], polarity per SEG_ACTIVE_LOW
//   seg_dp      decimal point, polarity per SEG_ACTIVE_LOW
//   digit_sel   one-hot digit select, polarity per SEL_ACTIVE_LOW
//   frame_done  1-cycle pulse when the last slot of a frame ends
module display_scanner #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int BLINK_SLOTS    = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FRAME_LAST = FW'(BLINK_SLOTS - 1);
  localparam logic [6:0]        SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF    = {DIGITS{SEL_ACTIVE_LOW}};

  // Font lookup, 1 = segment lit, a..g on bits 6..0.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'b1111110;
      4'h1: f = 7'b0110000;
      4'h2: f = 7'b1101101;
      4'h3: f = 7'b1111001;
      4'h4: f = 7'b0110011;
      4'h5: f = 7'b1011011;
      4'h6: f = 7'b1011111;
      4'h7: f = 7'b1110000;
      4'h8: f = 7'b1111111;
      4'h9: f = 7'b1111011;
      4'hA: f = 7'b1110111;
      4'hB: f = 7'b0011111;
      4'hC: f = 7'b1001110;
      4'hD: f = 7'b0111101;
      4'hE: f = 7'b1001111;
      default: f = 7'b1000111;
    endcase
    return f;
  endfunction

  // Map "lit" sense to the physical pin level.
  function automatic logic [6:0] seg_level(input logic [6:0] lit);
    return lit ^ SEG_OFF;
  endfunction

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic          phase;
  logic          boundary;

  logic [4*DIGITS-1:0] stg_value_p0;
  logic [DIGITS-1:0]   stg_dp_p0;
  logic [DIGITS-1:0]   stg_blank_p0;
  logic [DIGITS-1:0]   stg_blink_p0;

  logic [4*DIGITS-1:0] disp_value_p1;
  logic [DIGITS-1:0]   disp_dp_p1;
  logic [DIGITS-1:0]   disp_blank_p1;
  logic [DIGITS-1:0]   disp_blink_p1;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_dark;
  logic [DIGITS-1:0]   cur_sel;

  logic [6:0]          seg_p2;
  logic                seg_dp_p2;
  logic [DIGITS-1:0]   digit_sel_p2;
  logic                frame_done_p2;

  assign boundary = enable && (presc == PRESC_LAST) && (idx == IDX_LAST);

  // Scan control: prescaler, digit index, frame counter, blink phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc         <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      phase         <= 1'b0;
      frame_done_p2 <= 1'b0;
    end else begin
      frame_done_p2 <= 1'b0;
      if (enable) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          if (idx == IDX_LAST) begin
            idx           <= '0;
            frame_done_p2 <= 1'b1;
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              phase     <= ~phase;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  // Stage p0 -> p1: staging accepts loads any time; the display register
  // takes the staging contents only at the frame boundary. Non-blocking
  // semantics let a coincident load land in staging while the boundary
  // transfers the older staging contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stg_value_p0  <= '0;
      stg_dp_p0     <= '0;
      stg_blank_p0  <= '0;
      stg_blink_p0  <= '0;
      disp_value_p1 <= '0;
      disp_dp_p1    <= '0;
      disp_blank_p1 <= '0;
      disp_blink_p1 <= '0;
    end else begin
      if (load) begin
        stg_value_p0 <= value;
        stg_dp_p0    <= dp;
        stg_blank_p0 <= blank_mask;
        stg_blink_p0 <= blink_mask;
      end
      if (boundary) begin
        disp_value_p1 <= stg_value_p0;
        disp_dp_p1    <= stg_dp_p0;
        disp_blank_p1 <= stg_blank_p0;
        disp_blink_p1 <= stg_blink_p0;
      end
    end
  end

  // Select the current digit's data from the display register.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    cur_sel  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = disp_value_p1[4*i +: 4];
        cur_dp     = disp_dp_p1[i];
        cur_dark   = disp_blank_p1[i] | (disp_blink_p1[i] & phase);
        cur_sel[i] = 1'b1;
      end
    end
  end

  // Stage p1 -> p2: registered pin drivers. A dark digit keeps its select
  // asserted so the scan duty cycle of the other digits is unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_p2       <= SEG_OFF;
      seg_dp_p2    <= SEG_ACTIVE_LOW;
      digit_sel_p2 <= SEL_OFF;
    end else if (!enable) begin
      seg_p2       <= SEG_OFF;
      seg_dp_p2    <= SEG_ACTIVE_LOW;
      digit_sel_p2 <= SEL_OFF;
    end else begin
      seg_p2       <= seg_level(cur_dark ? 7'b0 : hex_font(cur_nib));
      seg_dp_p2    <= (cur_dp & ~cur_dark) ^ SEG_ACTIVE_LOW;
      digit_sel_p2 <= cur_sel ^ SEL_OFF;
    end
  end

  assign seg        = seg_p2;
  assign seg_dp     = seg_dp_p2;
  assign digit_sel  = digit_sel_p2;
  assign frame_done = frame_done_p2;

endmodule
